// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the serial adder sequencer.
// Optional build macro used by the design: SERIAL_ADD_SUB_EN (adds subtract mode).
package serial_add_pkg;

  // Sequencer states: accept, load operands, stream bits, add last pair, report.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Width of the shift-cycle counter that counts 0..width-1.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  // Carry-out of a full adder.
  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder with its carry flip-flop. The sum bit is combinational
// from the current inputs and stored carry; the carry advances on en and is
// (re)initialised on clr.
module serial_fa_cell
  import serial_add_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic init,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  logic c_q;
  logic c_d;

  // Next carry: initialise at operand load, otherwise ripple on each add cycle.
  always_comb begin
    c_d = c_q;
    if (clr) begin
      c_d = init;
    end else if (en) begin
      c_d = maj3(a, b, c_q);
    end
  end

  // Carry storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_q <= 1'b0;
    end else begin
      c_q <= c_d;
    end
  end

  assign s = a ^ b ^ c_q;
  assign c = c_q;

endmodule

// File: rtl/serial_add_ctrl.sv
// Sequencer for the parallel-load serial adder: loads both operand shift
// registers, streams them LSB first, adds the returned bits through a carry
// flip-flop and assembles the parallel sum and carry-out.
// Optional build macro: SERIAL_ADD_SUB_EN adds a 'sub' input selecting A - B.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             load,
  output logic             shift,
  input  logic             a_bit,
  input  logic             b_bit,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             done
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             add_en_q, add_en_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             sub_mode;
  logic             b_eff;
  logic             carry_clr;
  logic             fa_s;
  logic             fa_c;

`ifdef SERIAL_ADD_SUB_EN
  logic sub_q, sub_d;

  // Capture the operation mode only when a start is accepted.
  always_comb begin
    sub_d = sub_q;
    if (state_q == IDLE && start) begin
      sub_d = sub;
    end
  end

  // Mode register, held for the whole operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sub_q <= 1'b0;
    end else begin
      sub_q <= sub_d;
    end
  end

  assign sub_mode = sub_q;
`else
  assign sub_mode = 1'b0;
`endif

  // Subtraction is A + ~B + 1: invert B's bits and start with carry 1.
  assign b_eff     = b_bit ^ sub_mode;
  assign carry_clr = (state_q == LOAD);

  serial_fa_cell u_fa (
    .clk   (clk),
    .reset (reset),
    .clr   (carry_clr),
    .init  (sub_mode),
    .en    (add_en_q),
    .a     (a_bit),
    .b     (b_eff),
    .s     (fa_s),
    .c     (fa_c)
  );

  // State sequencing and shift-cycle counting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result assembly: operand bits return one cycle after each shift, so the
  // add enable is the shift strobe delayed by a cycle; the final pair arrives
  // in DRAIN, which is also where the carry-out is captured.
  always_comb begin
    add_en_d = (state_q == SHIFT);
    sum_d    = sum_q;
    cout_d   = cout_q;
    if (state_q == LOAD) begin
      sum_d  = '0;
      cout_d = 1'b0;
    end else if (add_en_q) begin
      sum_d = {fa_s, sum_q[WIDTH-1:1]};
      if (state_q == DRAIN) begin
        cout_d = maj3(a_bit, b_eff, fa_c);
      end
    end
  end

  // Sequencer and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      add_en_q <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      add_en_q <= add_en_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  // Strobes are decoded from state alone, so start never reaches an output.
  assign ready = (state_q == IDLE);
  assign load  = (state_q == LOAD);
  assign shift = (state_q == SHIFT);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
`timescale 1ns/1ps
module tb_serial_add_ctrl;

  localparam int W  = 4;
  localparam int W8 = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  // WIDTH=4 instance signals
  logic         start  = 1'b0;
  logic         sub_in = 1'b0;
  logic         ready, load, shift, done, cout;
  logic [W-1:0] sum;
  logic [W-1:0] a_in = '0, b_in = '0;
  logic [W-1:0] a_reg = '0, b_reg = '0;
  logic         a_bit = 1'b0, b_bit = 1'b0;

  // WIDTH=8 instance signals
  logic          start8 = 1'b0;
  logic          ready8, load8, shift8, done8, cout8;
  logic [W8-1:0] sum8;
  logic [W8-1:0] a8_in = '0, b8_in = '0;
  logic [W8-1:0] a8_reg = '0, b8_reg = '0;
  logic          a8_bit = 1'b0, b8_bit = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub_in),
`endif
    .ready (ready),
    .load  (load),
    .shift (shift),
    .a_bit (a_bit),
    .b_bit (b_bit),
    .sum   (sum),
    .cout  (cout),
    .done  (done)
  );

  serial_add_ctrl #(.WIDTH(W8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .start (start8),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (1'b0),
`endif
    .ready (ready8),
    .load  (load8),
    .shift (shift8),
    .a_bit (a8_bit),
    .b_bit (b8_bit),
    .sum   (sum8),
    .cout  (cout8),
    .done  (done8)
  );

  // Operand registers: load captures the word and drives 0; shift presents bit[0].
  always @(posedge clk) begin
    if (load) begin
      a_reg <= a_in;  b_reg <= b_in;  a_bit <= 1'b0;  b_bit <= 1'b0;
    end else if (shift) begin
      a_bit <= a_reg[0];  b_bit <= b_reg[0];
      a_reg <= a_reg >> 1; b_reg <= b_reg >> 1;
    end
    if (load8) begin
      a8_reg <= a8_in; b8_reg <= b8_in; a8_bit <= 1'b0; b8_bit <= 1'b0;
    end else if (shift8) begin
      a8_bit <= a8_reg[0]; b8_bit <= b8_reg[0];
      a8_reg <= a8_reg >> 1; b8_reg <= b8_reg >> 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Behavioural model: phase = cycles since the accepted start (0 = idle).
  // Result is plain modular arithmetic on the operands captured at acceptance.
  int           phase = 0;
  logic [W-1:0] m_sum = '0, m_a = '0, m_b = '0;
  logic         m_cout = 1'b0, m_sub = 1'b0;
  logic [W:0]   m_tmp;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      phase = 0; m_sum = '0; m_cout = 1'b0;
    end else if (phase == 0) begin
      if (start) begin
        phase = 1; m_a = a_in; m_b = b_in; m_sub = sub_in;
      end
    end else if (phase == W + 3) begin
      phase = 0;
    end else begin
      phase++;
      if (phase == W + 3) begin
        m_tmp  = {1'b0, m_a} + {1'b0, (m_sub ? ~m_b : m_b)} + {{W{1'b0}}, m_sub};
        m_sum  = m_tmp[W-1:0];
        m_cout = m_tmp[W];
      end
    end
  end

  // Per-cycle comparison of the WIDTH=4 instance against the model.
  always @(negedge clk) begin
    if (reset) begin
      check("rst_ready", ready, 1'b1);
      check("rst_strobes", {load, shift, done}, 3'b000);
      check("rst_result", {cout, sum}, '0);
    end else begin
      check("cyc_ready", ready, phase == 0);
      check("cyc_load", load, phase == 1);
      check("cyc_shift", shift, (phase >= 2) && (phase <= W + 1));
      check("cyc_done", done, phase == W + 3);
      check("cyc_load_shift_excl", load & shift, 1'b0);
      if (phase == 0 || phase == 1 || phase == W + 3) begin
        check("cyc_sum", sum, m_sum);
        check("cyc_cout", cout, m_cout);
      end else if (phase == 2) begin
        check("cyc_sum_cleared", sum, '0);
      end
    end
  end

  // One operation on the WIDTH=4 instance with literal expectations.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [W-1:0] exp_sum, input logic exp_cout, input string tag);
    int   n;
    logic seen;
    for (int i = 0; i < 20 && !ready; i++) begin
      @(posedge clk); #1;
    end
    a_in = a; b_in = b; sub_in = s;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1; seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (n == 1) check({tag, "_load_at_T+1"}, load, 1'b1);
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_done_seen"}, seen, 1'b1);
    check({tag, "_latency"}, n, 7);
    check({tag, "_sum"}, sum, exp_sum);
    check({tag, "_cout"}, cout, exp_cout);
    $display("op %s: A=%0d B=%0d sub=%0d -> sum=%0d cout=%0d after %0d cycles",
             tag, a, b, s, sum, cout, n);
    @(posedge clk); #1;
  endtask

  initial begin
    int loads, dones, n;
    logic seen;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    run_op(4'd9,  4'd5, 1'b0, 4'd14, 1'b0, "add_9_5");
    run_op(4'd15, 4'd1, 1'b0, 4'd0,  1'b1, "add_15_1");
    run_op(4'd0,  4'd0, 1'b0, 4'd0,  1'b0, "add_0_0");

    // start held high: accepted at T, T+8, T+16 only.
    a_in = 4'd6; b_in = 4'd7; sub_in = 1'b0;
    loads = 0; dones = 0;
    start = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (load) loads++;
      if (done) dones++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("held_start_loads", loads, 3);
    check("held_start_dones", dones, 3);
    check("held_start_sum", sum, 4'd13);
    $display("held start: loads=%0d dones=%0d sum=%0d", loads, dones, sum);

    // Reset on the second shift cycle.
    a_in = 4'd9; b_in = 4'd5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_reset_shift", shift, 1'b1);
    reset = 1'b1;
    #1;
    check("midrst_ready", ready, 1'b1);
    check("midrst_strobes", {load, shift, done}, 3'b000);
    check("midrst_result", {cout, sum}, '0);
    $display("mid-op reset: ready=%0d load=%0d shift=%0d done=%0d sum=%0d cout=%0d",
             ready, load, shift, done, sum, cout);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_op(4'd3, 4'd4, 1'b0, 4'd7, 1'b0, "after_reset_3_4");

`ifdef SERIAL_ADD_SUB_EN
    run_op(4'd5, 4'd9, 1'b1, 4'd12, 1'b0, "sub_5_9");
    run_op(4'd9, 4'd5, 1'b1, 4'd4,  1'b1, "sub_9_5");
    run_op(4'd9, 4'd5, 1'b0, 4'd14, 1'b0, "add_after_sub");
`endif

    // WIDTH=8 instance: 200 + 100 = 300 -> sum 44, carry 1, done at T+11.
    check("w8_idle_ready", ready8, 1'b1);
    a8_in = 8'd200; b8_in = 8'd100;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    n = 1; seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done8) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    check("w8_done_seen", seen, 1'b1);
    check("w8_latency", n, 11);
    check("w8_sum", sum8, 8'd44);
    check("w8_cout", cout8, 1'b1);
    $display("op w8: A=200 B=100 -> sum=%0d cout=%0d after %0d cycles", sum8, cout8, n);
    @(posedge clk); #1;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
